// File: rtl/if_id_hazard.sv
// IF/ID pipeline register with load-use hazard detection; one cycle fetch-to-decode latency.
// Backpressure: IFWrite drops for one cycle on a load-use pair, and a flush always overrides the stall.
module if_id_hazard #(
  parameter logic [31:0] NOP_INSN = 32'h00000013,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Instruction_if,
  input  logic [31:0]      PC_if,
  input  logic             IF_flush,
  input  logic             MemRead_ex,
  input  logic [4:0]       rd_ex,
  output logic             IFWrite,
  output logic [31:0]      Instruction_id,
  output logic [31:0]      PC_id,
  output logic             valid_id,
  output logic             bubble_ex,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       use_rs1;
  logic       use_rs2;
  logic       hazard;
  logic       stall;

  assign opcode = Instruction_id[6:0];
  assign rs1    = Instruction_id[19:15];
  assign rs2    = Instruction_id[24:20];

  // Unknown opcodes read no sources, so garbage words never stall fetch.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (opcode)
      OP_R, OP_STORE, OP_BRANCH: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      OP_I_ALU, OP_LOAD, OP_JALR: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = valid_id & MemRead_ex & (rd_ex != 5'd0) &
                  ((use_rs1 & (rs1 == rd_ex)) | (use_rs2 & (rs2 == rd_ex)));

  // Fetch ignores a redirect while held, so flush must win over stall.
  assign stall     = hazard & ~IF_flush;
  assign IFWrite   = ~stall;
  assign bubble_ex = stall;

  always_ff @(posedge clk) begin
    if (reset) begin
      Instruction_id <= NOP_INSN;
      PC_id          <= 32'd0;
      valid_id       <= 1'b0;
    end else if (IF_flush) begin
      Instruction_id <= NOP_INSN;
      PC_id          <= PC_if;
      valid_id       <= 1'b0;
    end else if (!stall) begin
      Instruction_id <= Instruction_if;
      PC_id          <= PC_if;
      valid_id       <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && (stall_cnt != '1))
        stall_cnt <= stall_cnt + CNT_W'(1);
      if (IF_flush && (flush_cnt != '1))
        flush_cnt <= flush_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_if_id_hazard.sv
// Directed bench for if_id_hazard; a second instance with 2-bit counters covers saturation.
module tb_if_id_hazard;

  logic        clk;
  logic        reset;
  logic [31:0] Instruction_if;
  logic [31:0] PC_if;
  logic        IF_flush;
  logic        MemRead_ex;
  logic [4:0]  rd_ex;

  logic        IFWrite, valid_id, bubble_ex;
  logic [31:0] Instruction_id, PC_id;
  logic [15:0] stall_cnt, flush_cnt;

  logic        IFWrite2, valid_id2, bubble_ex2;
  logic [31:0] Instruction_id2, PC_id2;
  logic [1:0]  stall_cnt2, flush_cnt2;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] NOP     = 32'h00000013;
  localparam logic [31:0] ADDI    = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] ADD_121 = 32'h00208133; // add x2,x1,x2
  localparam logic [31:0] LUI_0   = 32'h000010B7; // lui x1,1 (rs1 field 0)
  localparam logic [31:0] LUI_1   = 32'h000080B7; // lui x1,8 (rs1 field 1)
  localparam logic [31:0] ADD_000 = 32'h00000033; // add x0,x0,x0

  if_id_hazard #(.NOP_INSN(32'h00000013), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .PC_if(PC_if),
    .IF_flush(IF_flush), .MemRead_ex(MemRead_ex), .rd_ex(rd_ex),
    .IFWrite(IFWrite), .Instruction_id(Instruction_id), .PC_id(PC_id),
    .valid_id(valid_id), .bubble_ex(bubble_ex),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  if_id_hazard #(.NOP_INSN(32'h00000013), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .Instruction_if(Instruction_if), .PC_if(PC_if),
    .IF_flush(IF_flush), .MemRead_ex(MemRead_ex), .rd_ex(rd_ex),
    .IFWrite(IFWrite2), .Instruction_id(Instruction_id2), .PC_id(PC_id2),
    .valid_id(valid_id2), .bubble_ex(bubble_ex2),
    .stall_cnt(stall_cnt2), .flush_cnt(flush_cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; IF_flush = 1'b0; MemRead_ex = 1'b0; rd_ex = 5'd0;
    Instruction_if = 32'hDEADBEEF; PC_if = 32'h100;
    tick; tick;
    checks++; if (Instruction_id !== NOP) begin errors++; $display("FAIL reset_insn: got %h want %h", Instruction_id, NOP); end
    checks++; if (PC_id !== 32'd0) begin errors++; $display("FAIL reset_pc: got %h want 0", PC_id); end
    checks++; if (valid_id !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid_id); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin errors++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", stall_cnt, flush_cnt); end
    checks++; if (IFWrite !== 1'b1 || bubble_ex !== 1'b0) begin errors++; $display("FAIL reset_comb: got IFWrite=%b bubble=%b want 1/0", IFWrite, bubble_ex); end
    reset = 1'b0;
    Instruction_if = ADDI; PC_if = 32'h0;
    tick;
    checks++; if (Instruction_id !== ADDI) begin errors++; $display("FAIL stream_insn: got %h want %h", Instruction_id, ADDI); end
    checks++; if (PC_id !== 32'h0 || valid_id !== 1'b1) begin errors++; $display("FAIL stream_pc_valid: got %h/%b want 0/1", PC_id, valid_id); end
    checks++; if (IFWrite !== 1'b1) begin errors++; $display("FAIL stream_ifwrite: got %b want 1", IFWrite); end
  endtask

  task automatic test_load_use;
    Instruction_if = ADD_121; PC_if = 32'h4;
    tick;
    Instruction_if = ADDI; PC_if = 32'h8;
    MemRead_ex = 1'b1; rd_ex = 5'd2;
    #1;
    checks++; if (IFWrite !== 1'b0) begin errors++; $display("FAIL hazard_rs2: got IFWrite=%b want 0", IFWrite); end
    rd_ex = 5'd1;
    #1;
    checks++; if (IFWrite !== 1'b0 || bubble_ex !== 1'b1) begin errors++; $display("FAIL hazard_rs1: got IFWrite=%b bubble=%b want 0/1", IFWrite, bubble_ex); end
    tick;
    checks++; if (Instruction_id !== ADD_121 || PC_id !== 32'h4 || valid_id !== 1'b1) begin errors++; $display("FAIL stall_hold: got %h/%h/%b want %h/4/1", Instruction_id, PC_id, valid_id, ADD_121); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt1: got %0d want 1", stall_cnt); end
    MemRead_ex = 1'b0;
    #1;
    checks++; if (IFWrite !== 1'b1 || bubble_ex !== 1'b0) begin errors++; $display("FAIL stall_release: got IFWrite=%b bubble=%b want 1/0", IFWrite, bubble_ex); end
    tick;
    checks++; if (Instruction_id !== ADDI || PC_id !== 32'h8) begin errors++; $display("FAIL after_stall: got %h/%h want %h/8", Instruction_id, PC_id, ADDI); end
    checks++; if (stall_cnt !== 16'd1) begin errors++; $display("FAIL stall_cnt_keep: got %0d want 1", stall_cnt); end
  endtask

  task automatic test_no_hazard;
    logic [31:0] vec_insn [3];
    logic [4:0]  vec_rd   [3];
    vec_insn[0] = LUI_0;   vec_rd[0] = 5'd1;
    vec_insn[1] = LUI_1;   vec_rd[1] = 5'd1;
    vec_insn[2] = ADD_000; vec_rd[2] = 5'd0;
    for (int i = 0; i < 3; i++) begin
      MemRead_ex = 1'b0;
      Instruction_if = vec_insn[i]; PC_if = 32'h10 + 32'(i * 4);
      tick;
      MemRead_ex = 1'b1; rd_ex = vec_rd[i];
      #1;
      checks++; if (IFWrite !== 1'b1 || bubble_ex !== 1'b0) begin errors++; $display("FAIL no_hazard_%0d: got IFWrite=%b bubble=%b want 1/0", i, IFWrite, bubble_ex); end
    end
    MemRead_ex = 1'b0;
  endtask

  task automatic test_flush;
    Instruction_if = ADD_121; PC_if = 32'h20;
    tick;
    MemRead_ex = 1'b1; rd_ex = 5'd1; IF_flush = 1'b1;
    Instruction_if = ADDI; PC_if = 32'h40;
    #1;
    checks++; if (IFWrite !== 1'b1 || bubble_ex !== 1'b0) begin errors++; $display("FAIL flush_prio: got IFWrite=%b bubble=%b want 1/0", IFWrite, bubble_ex); end
    tick;
    checks++; if (Instruction_id !== NOP || valid_id !== 1'b0 || PC_id !== 32'h40) begin errors++; $display("FAIL flush_squash: got %h/%b/%h want %h/0/40", Instruction_id, valid_id, PC_id, NOP); end
    checks++; if (flush_cnt !== 16'd1 || stall_cnt !== 16'd1) begin errors++; $display("FAIL flush_cnt: got flush=%0d stall=%0d want 1/1", flush_cnt, stall_cnt); end
    IF_flush = 1'b0; MemRead_ex = 1'b0;
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 3; i++) begin
      Instruction_if = 32'h00100093 + 32'(i << 20); PC_if = 32'h80 + 32'(i * 4);
      tick;
      checks++; if (Instruction_id !== 32'h00100093 + 32'(i << 20) || PC_id !== 32'h80 + 32'(i * 4) || valid_id !== 1'b1) begin
        errors++; $display("FAIL b2b_%0d: got %h/%h/%b want %h/%h/1", i, Instruction_id, PC_id, valid_id, 32'h00100093 + 32'(i << 20), 32'h80 + 32'(i * 4));
      end
    end
  endtask

  task automatic test_saturation;
    reset = 1'b1; tick; reset = 1'b0;
    Instruction_if = ADD_121; PC_if = 32'h0; rd_ex = 5'd1;
    tick;
    for (int i = 1; i <= 5; i++) begin
      MemRead_ex = 1'b1;
      tick;
      MemRead_ex = 1'b0;
      tick;
      checks++; if (stall_cnt2 !== 2'((i > 3) ? 3 : i) || stall_cnt !== 16'(i)) begin
        errors++; $display("FAIL stall_sat_%0d: got %0d/%0d want %0d/%0d", i, stall_cnt2, stall_cnt, (i > 3) ? 3 : i, i);
      end
    end
    IF_flush = 1'b1;
    repeat (4) tick;
    IF_flush = 1'b0;
    checks++; if (flush_cnt2 !== 2'd3 || flush_cnt !== 16'd4) begin errors++; $display("FAIL flush_sat: got %0d/%0d want 3/4", flush_cnt2, flush_cnt); end
  endtask

  task automatic test_reset_mid_stall;
    Instruction_if = ADD_121; PC_if = 32'hC0; MemRead_ex = 1'b0;
    tick;
    MemRead_ex = 1'b1; rd_ex = 5'd1;
    #1;
    checks++; if (IFWrite !== 1'b0) begin errors++; $display("FAIL mid_stall_pre: got IFWrite=%b want 0", IFWrite); end
    reset = 1'b1;
    tick;
    checks++; if (valid_id !== 1'b0 || IFWrite !== 1'b1 || Instruction_id !== NOP) begin errors++; $display("FAIL mid_stall_reset: got valid=%b IFWrite=%b insn=%h want 0/1/%h", valid_id, IFWrite, Instruction_id, NOP); end
    checks++; if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 || stall_cnt2 !== 2'd0) begin errors++; $display("FAIL mid_stall_cnt: got %0d/%0d/%0d want 0/0/0", stall_cnt, flush_cnt, stall_cnt2); end
    reset = 1'b0; MemRead_ex = 1'b0;
  endtask

  initial begin
    test_reset;
    test_load_use;
    test_no_hazard;
    test_flush;
    test_back_to_back;
    test_saturation;
    test_reset_mid_stall;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
